// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, FSM state
// encodings, instruction field positions and the bundled control word.
package cpu_ctrl_pkg;

    // Instruction register field positions
    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;

    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_ROR  = 5'b00111;
    localparam logic [4:0] OPC_ROL  = 5'b01000;
    localparam logic [4:0] OPC_SHR  = 5'b01001;
    localparam logic [4:0] OPC_SHRA = 5'b01010;
    localparam logic [4:0] OPC_SHL  = 5'b01011;
    localparam logic [4:0] OPC_NEG  = 5'b10001;
    localparam logic [4:0] OPC_NOT  = 5'b10010;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_HALT = 4'd7
    } state_t;

    typedef struct packed {
        logic       pc_out;
        logic       zlow_out;
        logic       mdr_out;
        logic       mar_in;
        logic       z_in;
        logic       pc_in;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       inc_pc;
        logic       read;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       ba_out;
        logic [4:0] operation;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode classifier. Anything that is not ALU3, UNARY or HALT
// falls into the NOP class, so unknown opcodes execute as a no-op.
module control_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output logic       is_alu3,
    output logic       is_unary,
    output logic       is_nop,
    output logic       is_halt
);

    always_comb begin
        is_alu3  = 1'b0;
        is_unary = 1'b0;
        is_halt  = 1'b0;
        case (opcode)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ROR,
            OPC_ROL, OPC_SHR, OPC_SHRA, OPC_SHL: is_alu3  = 1'b1;
            OPC_NEG, OPC_NOT:                    is_unary = 1'b1;
            OPC_HALT:                            is_halt  = 1'b1;
            default: ;
        endcase
        is_nop = !(is_alu3 || is_unary || is_halt);
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer. State is registered; all controls are
// decoded combinationally from the state and the opcode field of IR.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int IR_W  = 32,
    parameter int OPC_W = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [IR_W-1:0]  IR,
    input  logic             Stop,
    output logic             PCout,
    output logic             ZLowout,
    output logic             MDRout,
    output logic             MARin,
    output logic             Zin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             IncPC,
    output logic             Read,
    output logic             GRA,
    output logic             GRB,
    output logic             GRC,
    output logic             Rin,
    output logic             Rout,
    output logic             BAout,
    output logic [OPC_W-1:0] operation,
    output logic             Run,
    output logic [3:0]       dbg_state
);

    state_t     state;
    logic       stop_pend;
    logic       stop_now;
    logic [4:0] opcode;
    logic       is_alu3;
    logic       is_unary;
    logic       is_nop;
    logic       is_halt;
    ctrl_t      ctrl;
    logic       ir_unused;

    assign opcode    = IR[OP_HI:OP_LO];
    assign ir_unused = ^{IR[RA_HI:RA_LO], IR[RB_HI:RB_LO], IR[RC_HI:RC_LO], IR[RC_LO-1:0]};
    assign stop_now  = stop_pend || Stop;

    control_decode u_decode (
        .opcode   (opcode),
        .is_alu3  (is_alu3),
        .is_unary (is_unary),
        .is_nop   (is_nop),
        .is_halt  (is_halt)
    );

    // The last execute state of each instruction diverts to HALT when a stop
    // has been requested at any point during that instruction.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= ST_RST;
            stop_pend <= 1'b0;
        end else begin
            if (Stop) begin
                stop_pend <= 1'b1;
            end
            case (state)
                ST_RST: state <= ST_T0;
                ST_T0:  state <= ST_T1;
                ST_T1:  state <= ST_T2;
                ST_T2:  state <= ST_T3;
                ST_T3: begin
                    if (is_halt) begin
                        state <= ST_HALT;
                    end else if (is_nop) begin
                        state <= stop_now ? ST_HALT : ST_T0;
                    end else begin
                        state <= ST_T4;
                    end
                end
                ST_T4: begin
                    if (is_unary) begin
                        state <= stop_now ? ST_HALT : ST_T0;
                    end else begin
                        state <= ST_T5;
                    end
                end
                ST_T5:   state <= stop_now ? ST_HALT : ST_T0;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_RST;
            endcase
        end
    end

    always_comb begin
        ctrl = '0;
        case (state)
            ST_T0: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
                ctrl.z_in   = 1'b1;
            end
            ST_T1: begin
                ctrl.zlow_out = 1'b1;
                ctrl.pc_in    = 1'b1;
                ctrl.read     = 1'b1;
                ctrl.mdr_in   = 1'b1;
            end
            ST_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            ST_T3: begin
                if (is_alu3) begin
                    ctrl.grb   = 1'b1;
                    ctrl.r_out = 1'b1;
                    ctrl.y_in  = 1'b1;
                end else if (is_unary) begin
                    ctrl.grb       = 1'b1;
                    ctrl.r_out     = 1'b1;
                    ctrl.z_in      = 1'b1;
                    ctrl.operation = opcode;
                end
            end
            ST_T4: begin
                if (is_alu3) begin
                    ctrl.grc       = 1'b1;
                    ctrl.r_out     = 1'b1;
                    ctrl.z_in      = 1'b1;
                    ctrl.operation = opcode;
                end else if (is_unary) begin
                    ctrl.zlow_out = 1'b1;
                    ctrl.gra      = 1'b1;
                    ctrl.r_in     = 1'b1;
                end
            end
            ST_T5: begin
                if (is_alu3) begin
                    ctrl.zlow_out = 1'b1;
                    ctrl.gra      = 1'b1;
                    ctrl.r_in     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign PCout     = ctrl.pc_out;
    assign ZLowout   = ctrl.zlow_out;
    assign MDRout    = ctrl.mdr_out;
    assign MARin     = ctrl.mar_in;
    assign Zin       = ctrl.z_in;
    assign PCin      = ctrl.pc_in;
    assign MDRin     = ctrl.mdr_in;
    assign IRin      = ctrl.ir_in;
    assign Yin       = ctrl.y_in;
    assign IncPC     = ctrl.inc_pc;
    assign Read      = ctrl.read;
    assign GRA       = ctrl.gra;
    assign GRB       = ctrl.grb;
    assign GRC       = ctrl.grc;
    assign Rin       = ctrl.r_in;
    assign Rout      = ctrl.r_out;
    assign BAout     = ctrl.ba_out;
    assign operation = ctrl.operation;
    assign Run       = (state != ST_RST) && (state != ST_HALT);
    assign dbg_state = state;

endmodule
